// File: rtl/flush_scheduler.sv
// Round-robin arbiter that lends a single AXI FIFO flusher to NUM_CH trace FIFOs,
// pointing each dump at that channel's own memory region.
module flush_scheduler #(
  parameter int          NUM_CH       = 4,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [63:0] STRIDE_BYTES = 64'h0000_0000_0010_0000,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         enable,
  input  logic [63:0]                  base_ptr,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
  output logic [NUM_CH-1:0]            ch_rd_en,
  output logic [NUM_CH-1:0]            ch_done,
  output logic                         fl_start,
  input  logic                         fl_idle,
  output logic [63:0]                  fl_base_ptr,
  input  logic                         fl_rd_en,
  output logic [DATA_WIDTH-1:0]        fl_dout,
  output logic                         fl_empty,
  output logic                         fl_valid,
  output logic                         busy,
  output logic [CH_W-1:0]              grant_id,
  output logic [31:0]                  last_words
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     pick_id;
  logic                pick_ok;
  logic [31:0]         word_cnt;
  logic [NUM_CH-1:0]   eligible;
  logic [2*NUM_CH-1:0] rotated;
  logic [CH_W:0]       slot;

  // Empty FIFOs are masked out: the flusher always performs one read, even on an empty FIFO.
  assign eligible = ch_req & ~ch_empty;
  assign rotated  = {eligible, eligible} >> rr_ptr;

  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
    slot    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      slot = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (slot >= (CH_W+1)'(NUM_CH)) slot = slot - (CH_W+1)'(NUM_CH);
      if (!pick_ok && rotated[k]) begin
        pick_ok = 1'b1;
        pick_id = slot[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable && pick_ok && fl_idle) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!fl_idle) state_next = WAIT_IDLE;
      WAIT_IDLE: if (fl_idle) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      fl_base_ptr <= '0;
      word_cnt    <= '0;
      last_words  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == START) begin
        grant_id    <= pick_id;
        fl_base_ptr <= base_ptr + 64'(pick_id) * STRIDE_BYTES;
        word_cnt    <= '0;
      end
      if ((state == WAIT_BUSY || state == WAIT_IDLE) && fl_rd_en && word_cnt != 32'hFFFF_FFFF)
        word_cnt <= word_cnt + 32'd1;
      if (state == DONE) begin
        last_words <= word_cnt;
        rr_ptr     <= (grant_id == CH_W'(NUM_CH-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign fl_start = (state == START);
  assign busy     = (state != IDLE);

  // The FIFO steering only follows the registered grant, never the live arbitration result.
  always_comb begin
    fl_dout  = '0;
    fl_empty = 1'b1;
    fl_valid = 1'b0;
    ch_rd_en = '0;
    ch_done  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state != IDLE && grant_id == CH_W'(i)) begin
        fl_dout     = ch_dout[i*DATA_WIDTH +: DATA_WIDTH];
        fl_empty    = ch_empty[i];
        fl_valid    = ch_valid[i];
        ch_rd_en[i] = fl_rd_en;
      end
      ch_done[i] = (state == DONE) && (grant_id == CH_W'(i));
    end
  end

endmodule

// File: tb/tb_flush_scheduler.sv
// Randomized bench for flush_scheduler with queue-based trace FIFOs and a simple
// flusher model that drains the steered FIFO and reports idle when it runs dry.
module tb_flush_scheduler;

  localparam int          NUM_CH = 4;
  localparam int          DW     = 32;
  localparam logic [63:0] STRIDE = 64'h0000_0000_0010_0000;

  logic                 aclk;
  logic                 areset;
  logic                 enable;
  logic [63:0]          base_ptr;
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_empty;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*DW-1:0] ch_dout;
  logic [NUM_CH-1:0]    ch_rd_en;
  logic [NUM_CH-1:0]    ch_done;
  logic                 fl_start;
  logic                 fl_idle;
  logic [63:0]          fl_base_ptr;
  logic                 fl_rd_en;
  logic [DW-1:0]        fl_dout;
  logic                 fl_empty;
  logic                 fl_valid;
  logic                 busy;
  logic [1:0]           grant_id;
  logic [31:0]          last_words;

  flush_scheduler #(
    .NUM_CH      (NUM_CH),
    .DATA_WIDTH  (DW),
    .STRIDE_BYTES(STRIDE)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .base_ptr   (base_ptr),
    .ch_req     (ch_req),
    .ch_empty   (ch_empty),
    .ch_valid   (ch_valid),
    .ch_dout    (ch_dout),
    .ch_rd_en   (ch_rd_en),
    .ch_done    (ch_done),
    .fl_start   (fl_start),
    .fl_idle    (fl_idle),
    .fl_base_ptr(fl_base_ptr),
    .fl_rd_en   (fl_rd_en),
    .fl_dout    (fl_dout),
    .fl_empty   (fl_empty),
    .fl_valid   (fl_valid),
    .busy       (busy),
    .grant_id   (grant_id),
    .last_words (last_words)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [DW-1:0]     fifo [NUM_CH][$];
  logic [NUM_CH-1:0] scramble;
  int                total;
  int                passed;
  int                cyc;
  int                start_cnt;
  int                start_cyc;
  int                done_cnt;
  logic [1:0]        start_grant;
  logic [63:0]       start_base;
  logic [NUM_CH-1:0] done_vec;
  logic [NUM_CH-1:0] rd_seen;
  logic [DW-1:0]     rd_data [$];
  bit                fl_busy_m;
  bit                fl_stop_next;
  int                mdl_rr;

  task automatic update_pins();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_empty[i] = (fifo[i].size() == 0);
      ch_dout[i*DW +: DW] = ((fifo[i].size() != 0) ? fifo[i][0] : '0) ^ (scramble[i] ? DW'($urandom) : '0);
    end
  endtask

  task automatic fill(input int ch, input int n);
    repeat (n) fifo[ch].push_back(DW'($urandom));
    update_pins();
  endtask

  task automatic clear_logs();
    start_cnt   = 0;
    done_cnt    = 0;
    start_grant = '0;
    start_base  = '0;
    done_vec    = '0;
    rd_seen     = '0;
    rd_data.delete();
  endtask

  // One clock: log what the DUT shows mid-cycle, then update FIFOs and the flusher model.
  task automatic tick();
    logic [NUM_CH-1:0] rd;
    bit st;
    @(negedge aclk);
    cyc++;
    rd = ch_rd_en;
    st = fl_start;
    if (st) begin
      start_cnt++;
      start_cyc   = cyc;
      start_grant = grant_id;
      start_base  = fl_base_ptr;
    end
    if (ch_done != '0) begin
      done_cnt++;
      done_vec |= ch_done;
    end
    rd_seen |= rd;
    if (fl_rd_en) rd_data.push_back(fl_dout);
    @(posedge aclk);
    #1;
    for (int i = 0; i < NUM_CH; i++)
      if (rd[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    ch_valid = rd;
    update_pins();
    if (st) begin
      fl_busy_m    = 1'b1;
      fl_idle      = 1'b0;
      fl_stop_next = 1'b0;
    end else if (fl_busy_m && fl_stop_next) begin
      fl_busy_m = 1'b0;
      fl_idle   = 1'b1;
    end
    #1;
    fl_rd_en     = fl_busy_m && !fl_empty;
    fl_stop_next = fl_busy_m && fl_empty;
  endtask

  // Reference arbitration: first requesting, non-empty channel at or after the rr pointer.
  function automatic int pick();
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (mdl_rr + k) % NUM_CH;
      if (ch_req[c] && fifo[c].size() != 0) return c;
    end
    return -1;
  endfunction

  task automatic run_dump(input bit drop_en, input bit abort_mid, output bit timed_out);
    int n = 0;
    clear_logs();
    timed_out = 1'b0;
    while (done_cnt == 0) begin
      if (n == 200) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      n++;
      if (rd_data.size() != 0 && drop_en) enable = 1'b0;
      if (rd_data.size() != 0 && abort_mid) return;
    end
  endtask

  task automatic do_reset();
    areset       = 1'b1;
    fl_busy_m    = 1'b0;
    fl_stop_next = 1'b0;
    fl_idle      = 1'b1;
    fl_rd_en     = 1'b0;
    ch_valid     = '0;
    ch_req       = '0;
    scramble     = '0;
    for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
    update_pins();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    mdl_rr = 0;
    #1;
  endtask

  task automatic test_reset();
    enable   = 1'b0;
    base_ptr = 64'h0;
    do_reset();
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0h want 0", busy); else passed++;
    total++; if (grant_id !== 2'd0) $display("[TB] FAIL reset_grant: got %0h want 0", grant_id); else passed++;
    total++; if (fl_start !== 1'b0) $display("[TB] FAIL reset_start: got %0h want 0", fl_start); else passed++;
    total++; if (ch_done !== 4'h0) $display("[TB] FAIL reset_done: got %0h want 0", ch_done); else passed++;
    total++; if (last_words !== 32'd0) $display("[TB] FAIL reset_last_words: got %0h want 0", last_words); else passed++;
    total++; if (fl_base_ptr !== 64'd0) $display("[TB] FAIL reset_base: got %0h want 0", fl_base_ptr); else passed++;
    total++; if (fl_empty !== 1'b1 || fl_valid !== 1'b0 || fl_dout !== '0)
      $display("[TB] FAIL reset_idle_mux: got empty=%0h valid=%0h dout=%0h want 1/0/0", fl_empty, fl_valid, fl_dout);
    else passed++;
    total++; if (ch_rd_en !== 4'h0) $display("[TB] FAIL reset_rd_en: got %0h want 0", ch_rd_en); else passed++;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_data [$];
    int exp, cyc0, bad;
    bit to;
    do_reset();
    base_ptr = 64'h1000_0000;
    enable   = 1'b1;
    fill(1, 3);
    ch_req  = 4'b0010;
    fl_idle = 1'b0;
    clear_logs();
    repeat (4) tick();
    total++; if (start_cnt !== 0) $display("[TB] FAIL single_hold_while_flusher_busy: got %0d starts want 0", start_cnt); else passed++;
    fl_idle  = 1'b1;
    exp      = pick();
    exp_data = fifo[1];
    cyc0     = cyc;
    run_dump(1'b0, 1'b0, to);
    bad = 0;
    for (int i = 0; i < rd_data.size() && i < exp_data.size(); i++) if (rd_data[i] !== exp_data[i]) bad++;
    total++; if (to !== 1'b0) $display("[TB] FAIL single_timeout: got %0h want 0", to); else passed++;
    total++; if (start_cnt !== 1) $display("[TB] FAIL single_start_count: got %0d want 1", start_cnt); else passed++;
    total++; if (start_cyc - cyc0 !== 2) $display("[TB] FAIL single_latency: got %0d want 2", start_cyc - cyc0); else passed++;
    total++; if (start_grant !== 2'(exp)) $display("[TB] FAIL single_grant: got %0d want %0d", start_grant, exp); else passed++;
    total++; if (start_base !== 64'h1010_0000) $display("[TB] FAIL single_base: got %0h want 10100000", start_base); else passed++;
    total++; if (rd_data.size() !== 3 || bad !== 0) $display("[TB] FAIL single_data: got %0d words %0d bad want 3 words 0 bad", rd_data.size(), bad); else passed++;
    total++; if (rd_seen !== 4'b0010) $display("[TB] FAIL single_rd_en: got %0h want 2", rd_seen); else passed++;
    total++; if (done_cnt !== 1 || done_vec !== 4'b0010) $display("[TB] FAIL single_done: got %0d pulses vec %0h want 1 pulse vec 2", done_cnt, done_vec); else passed++;
    total++; if (last_words !== 32'd3) $display("[TB] FAIL single_last_words: got %0d want 3", last_words); else passed++;
  endtask

  task automatic test_round_robin();
    int exp, exp_n;
    logic [NUM_CH-1:0] oh;
    bit to;
    do_reset();
    enable   = 1'b1;
    base_ptr = {$urandom, $urandom};
    ch_req   = 4'b1111;
    for (int d = 0; d < 5; d++) begin
      for (int i = 0; i < NUM_CH; i++) if (fifo[i].size() == 0) fill(i, $urandom_range(1, 4));
      exp   = pick();
      exp_n = fifo[exp].size();
      oh    = NUM_CH'(1) << exp;
      run_dump(1'b0, 1'b0, to);
      total++; if (to || start_grant !== 2'(exp)) $display("[TB] FAIL rr_grant_%0d: got %0d want %0d (timeout %0d)", d, start_grant, exp, to); else passed++;
      total++; if (done_cnt !== 1 || done_vec !== oh) $display("[TB] FAIL rr_done_%0d: got %0d pulses vec %0h want 1 pulse vec %0h", d, done_cnt, done_vec, oh); else passed++;
      total++; if (last_words !== 32'(exp_n)) $display("[TB] FAIL rr_last_words_%0d: got %0d want %0d", d, last_words, exp_n); else passed++;
      total++; if (start_base !== base_ptr + 64'(exp) * STRIDE) $display("[TB] FAIL rr_base_%0d: got %0h want %0h", d, start_base, base_ptr + 64'(exp) * STRIDE); else passed++;
      mdl_rr = (exp + 1) % NUM_CH;
    end
  endtask

  task automatic test_empty_skip();
    int exp;
    bit to;
    do_reset();
    enable = 1'b1;
    fill(2, $urandom_range(1, 4));
    ch_req = 4'b0101;
    exp    = pick();
    run_dump(1'b0, 1'b0, to);
    total++; if (to || start_grant !== 2'd2 || exp != 2) $display("[TB] FAIL skip_grant: got %0d want 2 (model %0d)", start_grant, exp); else passed++;
    total++; if (rd_seen !== 4'b0100 || done_vec !== 4'b0100) $display("[TB] FAIL skip_channels: got rd %0h done %0h want 4/4", rd_seen, done_vec); else passed++;
    mdl_rr = 3;
    clear_logs();
    repeat (10) tick();
    total++; if (start_cnt !== 0 || rd_seen !== 4'b0000) $display("[TB] FAIL skip_empty_only: got %0d starts rd %0h want 0/0", start_cnt, rd_seen); else passed++;
  endtask

  task automatic test_enable_drop();
    int exp;
    bit to;
    do_reset();
    enable = 1'b1;
    fill(3, 4);
    fill(0, 2);
    ch_req = 4'b1000;
    run_dump(1'b1, 1'b0, to);
    mdl_rr = 0;
    total++; if (to || done_vec !== 4'b1000) $display("[TB] FAIL drop_done: got %0h want 8 (timeout %0d)", done_vec, to); else passed++;
    total++; if (last_words !== 32'd4) $display("[TB] FAIL drop_last_words: got %0d want 4", last_words); else passed++;
    ch_req = 4'b1001;
    clear_logs();
    repeat (10) tick();
    total++; if (start_cnt !== 0 || busy !== 1'b0) $display("[TB] FAIL drop_no_new_grant: got %0d starts busy %0h want 0/0", start_cnt, busy); else passed++;
    enable = 1'b1;
    exp    = pick();
    run_dump(1'b0, 1'b0, to);
    total++; if (to || start_grant !== 2'(exp)) $display("[TB] FAIL drop_resume_grant: got %0d want %0d", start_grant, exp); else passed++;
  endtask

  task automatic test_isolation();
    logic [DW-1:0] exp_data [$];
    int bad;
    bit to;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < NUM_CH; i++) fill(i, 3);
    ch_req   = 4'b0100;
    scramble = 4'b1011;
    update_pins();
    exp_data = fifo[2];
    run_dump(1'b0, 1'b0, to);
    bad = 0;
    for (int i = 0; i < rd_data.size() && i < exp_data.size(); i++) if (rd_data[i] !== exp_data[i]) bad++;
    total++; if (to || rd_data.size() !== 3 || bad !== 0) $display("[TB] FAIL iso_data: got %0d words %0d bad want 3 words 0 bad", rd_data.size(), bad); else passed++;
    total++; if (rd_seen !== 4'b0100) $display("[TB] FAIL iso_rd_en: got %0h want 4", rd_seen); else passed++;
    total++; if (fifo[0].size() + fifo[1].size() + fifo[3].size() !== 9) $display("[TB] FAIL iso_untouched: got %0d words left want 9", fifo[0].size() + fifo[1].size() + fifo[3].size()); else passed++;
    scramble = '0;
    update_pins();
  endtask

  task automatic test_reset_mid();
    int exp;
    bit to;
    do_reset();
    enable = 1'b1;
    fill(2, 2);
    ch_req = 4'b0100;
    run_dump(1'b0, 1'b0, to);
    mdl_rr = 3;
    fill(3, 5);
    ch_req = 4'b1000;
    run_dump(1'b0, 1'b1, to);
    @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || fl_start !== 1'b0 || ch_done !== 4'h0) $display("[TB] FAIL abort_state: got busy %0h start %0h done %0h want 0/0/0", busy, fl_start, ch_done); else passed++;
    total++; if (grant_id !== 2'd0 || fl_base_ptr !== 64'd0) $display("[TB] FAIL abort_grant: got %0d base %0h want 0/0", grant_id, fl_base_ptr); else passed++;
    total++; if (last_words !== 32'd0 || ch_rd_en !== 4'h0) $display("[TB] FAIL abort_counters: got last %0d rd %0h want 0/0", last_words, ch_rd_en); else passed++;
    fl_busy_m    = 1'b0;
    fl_stop_next = 1'b0;
    fl_idle      = 1'b1;
    fl_rd_en     = 1'b0;
    ch_req       = '0;
    for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
    update_pins();
    mdl_rr = 0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    clear_logs();
    repeat (3) tick();
    total++; if (done_cnt !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses want 0", done_cnt); else passed++;
    fill(0, 2);
    fill(3, 2);
    ch_req = 4'b1001;
    exp    = pick();
    run_dump(1'b0, 1'b0, to);
    total++; if (to || start_grant !== 2'(exp) || done_vec !== 4'b0001) $display("[TB] FAIL abort_regrant: got %0d done %0h want %0d done 1", start_grant, done_vec, exp); else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_data [$];
    logic [NUM_CH-1:0] oh;
    int exp, bad;
    bit to;
    do_reset();
    enable   = 1'b1;
    base_ptr = {$urandom, $urandom};
    for (int d = 0; d < 8; d++) begin
      ch_req = NUM_CH'($urandom_range(1, 15));
      for (int i = 0; i < NUM_CH; i++)
        if (fifo[i].size() == 0 && $urandom_range(0, 2) != 0) fill(i, $urandom_range(1, 5));
      exp = pick();
      if (exp < 0) begin
        for (int i = NUM_CH - 1; i >= 0; i--) if (ch_req[i]) exp = i;
        fill(exp, 2);
        exp = pick();
      end
      exp_data = fifo[exp];
      oh       = NUM_CH'(1) << exp;
      run_dump(1'b0, 1'b0, to);
      bad = 0;
      for (int i = 0; i < rd_data.size() && i < exp_data.size(); i++) if (rd_data[i] !== exp_data[i]) bad++;
      total++; if (to || start_grant !== 2'(exp)) $display("[TB] FAIL rand_grant_%0d: got %0d want %0d", d, start_grant, exp); else passed++;
      total++; if (last_words !== 32'(exp_data.size()) || bad !== 0) $display("[TB] FAIL rand_words_%0d: got %0d words %0d bad want %0d words 0 bad", d, last_words, bad, exp_data.size()); else passed++;
      total++; if (rd_seen !== oh || done_vec !== oh) $display("[TB] FAIL rand_onehot_%0d: got rd %0h done %0h want %0h", d, rd_seen, done_vec, oh); else passed++;
      mdl_rr = (exp + 1) % NUM_CH;
    end
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    cyc      = 0;
    areset   = 1'b1;
    enable   = 1'b0;
    base_ptr = '0;
    ch_req   = '0;
    ch_valid = '0;
    ch_empty = '1;
    ch_dout  = '0;
    fl_idle  = 1'b1;
    fl_rd_en = 1'b0;
    scramble = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_empty_skip();
    test_enable_drop();
    test_isolation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/flush_scheduler.md
Name: flush_scheduler

Overview:
- Round-robin scheduler that shares one AXI FIFO flusher between NUM_CH trace FIFOs.
- Selects an eligible channel and steers that FIFO's read interface to the flusher.
- Programs the flusher base pointer to a per-channel memory region, issues a start pulse and waits for the flusher to return idle.
- Reports per-channel completion and the word count of the last dump. Sits between the trace FIFOs and the flusher in the capture-to-host path.

Parameters:
NUM_CH, 4, number of requesting FIFO channels (1..16)
DATA_WIDTH, 32, FIFO data width, passed through to the flusher
STRIDE_BYTES, 64'h0000_0000_0010_0000, byte distance between consecutive channel regions

Ports:
aclk  input  1  clock
areset  input  1  asynchronous, active-high reset
enable  input  1  scheduler may start new dumps
base_ptr  input  64  byte address of channel 0 region
ch_req  input  NUM_CH  per-channel dump request (level)
ch_empty  input  NUM_CH  per-channel FIFO empty
ch_valid  input  NUM_CH  per-channel FIFO read-data valid
ch_dout  input  NUM_CH*DATA_WIDTH  per-channel FIFO data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
ch_rd_en  output  NUM_CH  per-channel FIFO read enable
ch_done  output  NUM_CH  one-cycle pulse when the channel's dump completes
fl_start  output  1  start_dump to flusher
fl_idle  input  1  dump_idle from flusher
fl_base_ptr  output  64  base_ptr to flusher
fl_rd_en  input  1  fifo_rd_en from flusher
fl_dout  output  DATA_WIDTH  fifo_dout to flusher
fl_empty  output  1  fifo_empty to flusher
fl_valid  output  1  fifo_data_valid to flusher
busy  output  1  dump in progress (state != IDLE)
grant_id  output  CH_W  currently or last granted channel, CH_W = max(1,$clog2(NUM_CH))
last_words  output  32  fl_rd_en pulses counted during the last completed dump

Behaviour:
- Reset values: state IDLE; grant_id 0; rr pointer 0 (channel 0 has first priority); fl_base_ptr = 0.
- Reset values, continued: fl_start 0; ch_done 0; last_words 0; word counter 0.
- Eligible channel i: ch_req[i]=1 and ch_empty[i]=0. Empty channels are never granted, because the flusher reads once even when empty.
- Round-robin: search starts at rr pointer and wraps modulo NUM_CH; the first eligible channel wins. After DONE, rr pointer = grant+1 mod NUM_CH.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_IDLE, DONE.
- IDLE: if enable and any channel eligible and fl_idle=1, then register grant_id and set fl_base_ptr = base_ptr + grant*STRIDE_BYTES (64-bit, wraps mod 2^64); clear word counter; go to START.
- START: fl_start=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: stay until fl_idle=0, then go to WAIT_IDLE. There is no timeout.
- WAIT_IDLE: stay until fl_idle=1, then go to DONE.
- DONE: ch_done[grant]=1 for one cycle; last_words = word counter; advance rr pointer; go to IDLE.
- Latency: eligibility sampled in IDLE at cycle N gives fl_start high at N+1. Back-to-back dumps have a minimum gap of 1 IDLE cycle after DONE.
- fl_base_ptr is registered and stays stable from START until the next grant.
- Mux, combinational from registered grant_id, valid in START..DONE:
  - fl_dout = ch_dout[grant]; fl_empty = ch_empty[grant]; fl_valid = ch_valid[grant].
  - ch_rd_en[grant] = fl_rd_en; all other ch_rd_en = 0.
- Mux in IDLE: fl_empty=1, fl_valid=0, fl_dout=0, all ch_rd_en=0.
- Word counter: increments on fl_rd_en during WAIT_BUSY/WAIT_IDLE; saturates at 32'hFFFF_FFFF.
- enable deasserted mid-dump: the current dump completes; no new grant is issued.
- ch_req[grant] deasserted mid-dump: ignored; the dump runs until the flusher drains the FIFO.
- Simultaneous requests are resolved by the rr pointer only.
- areset mid-dump: all state returns to reset values immediately. The flusher must be reset concurrently; no ch_done is emitted for the aborted dump.
- fl_idle=0 while in IDLE: no grant is issued until it returns to 1.

Test Plan:
1. Single channel: ch_req=4'b0010, ch1 holds 3 words, base_ptr=0x1000_0000 -> fl_base_ptr=0x1010_0000; fl_start for 1 cycle at N+1; ch_rd_en[1] pulses 3 times; ch_done=4'b0010; last_words=3.
2. Round-robin fairness: ch_req=4'b1111, all FIFOs non-empty and refilled -> grant order 0,1,2,3,0; each ch_done pulse exactly once per dump.
3. Empty skip: ch_req=4'b0101, ch_empty=4'b0001 -> only ch2 granted; ch0 never granted; fl_start never issued while only ch0 requests.
4. Enable drop: deassert enable during WAIT_IDLE of a ch3 dump -> ch_done[3] still pulses; no further fl_start while enable=0.
5. Isolation: during a ch2 dump, ch_dout of ch0/1/3 toggled -> fl_dout equals ch2 data only; ch_rd_en[0,1,3] stay 0.
6. Reset mid-dump: assert areset in WAIT_IDLE -> busy=0, fl_start=0, ch_done=0, grant_id=0 asynchronously. The next request after release is granted starting from ch0.
